// File: rtl/alu_cmd_issuer.sv
// Command issuer for a combinational ALU: accepts one tagged command, drives the ALU
// for a fixed settle time, captures the result and returns a tagged response.
module alu_cmd_issuer #(
  parameter int unsigned DATA_LEN   = 4,
  parameter int unsigned TAG_W      = 3,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [DATA_LEN-1:0] cmd_a,
  input  logic [DATA_LEN-1:0] cmd_b,
  input  logic [TAG_W-1:0]    cmd_tag,
  output logic [DATA_LEN-1:0] alu_a,
  output logic [DATA_LEN-1:0] alu_b,
  output logic [3:0]          alu_sel,
  input  logic [DATA_LEN-1:0] alu_result,
  input  logic                alu_overflow,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_result,
  output logic                rsp_zero,
  output logic                rsp_ovf,
  output logic                rsp_err,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [CNT_W-1:0]    done_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int unsigned SET_W       = 4;
  localparam logic [3:0]  SEL_IDLE    = 4'b1111;
  localparam logic [3:0]  OP_ADD      = 4'd0;
  localparam logic [3:0]  OP_SUB      = 4'd1;
  localparam logic [3:0]  OP_MAX_LEGAL = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESP
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [SET_W-1:0]    r_settle,     w_settle_nxt;
  logic                r_cmd_ready,  w_cmd_ready_nxt;
  logic [DATA_LEN-1:0] r_alu_a,      w_alu_a_nxt;
  logic [DATA_LEN-1:0] r_alu_b,      w_alu_b_nxt;
  logic [3:0]          r_alu_sel,    w_alu_sel_nxt;
  logic                r_rsp_valid,  w_rsp_valid_nxt;
  logic [DATA_LEN-1:0] r_rsp_result, w_rsp_result_nxt;
  logic                r_rsp_zero,   w_rsp_zero_nxt;
  logic                r_rsp_ovf,    w_rsp_ovf_nxt;
  logic                r_rsp_err,    w_rsp_err_nxt;
  logic [TAG_W-1:0]    r_rsp_tag,    w_rsp_tag_nxt;
  logic [CNT_W-1:0]    r_done_cnt,   w_done_cnt_nxt;
  logic [CNT_W-1:0]    r_err_cnt,    w_err_cnt_nxt;

  logic w_accept;
  logic w_op_legal;
  logic w_sel_arith;

  assign w_accept    = cmd_valid & r_cmd_ready;
  assign w_op_legal  = (cmd_op <= OP_MAX_LEGAL);
  // Overflow is only meaningful for add/sub; the latched operator is still on alu_sel in DRIVE.
  assign w_sel_arith = (r_alu_sel == OP_ADD) | (r_alu_sel == OP_SUB);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle     <= '0;
      r_cmd_ready  <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= SEL_IDLE;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
      r_done_cnt   <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle     <= w_settle_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_sel    <= w_alu_sel_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_zero   <= w_rsp_zero_nxt;
      r_rsp_ovf    <= w_rsp_ovf_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_rsp_tag    <= w_rsp_tag_nxt;
      r_done_cnt   <= w_done_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_nxt     = r_settle;
    w_cmd_ready_nxt  = r_cmd_ready;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_sel_nxt    = r_alu_sel;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_zero_nxt   = r_rsp_zero;
    w_rsp_ovf_nxt    = r_rsp_ovf;
    w_rsp_err_nxt    = r_rsp_err;
    w_rsp_tag_nxt    = r_rsp_tag;
    w_done_cnt_nxt   = r_done_cnt;
    w_err_cnt_nxt    = r_err_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cmd_ready_nxt = 1'b0;
          w_rsp_tag_nxt   = cmd_tag;
          if (w_op_legal) begin
            w_state_nxt   = ST_DRIVE;
            w_settle_nxt  = SET_W'(SETTLE_CYC);
            w_alu_a_nxt   = cmd_a;
            w_alu_b_nxt   = cmd_b;
            w_alu_sel_nxt = cmd_op;
          end else begin
            // Illegal op short-circuits to a response without touching the ALU.
            w_state_nxt      = ST_RESP;
            w_rsp_valid_nxt  = 1'b1;
            w_rsp_err_nxt    = 1'b1;
            w_rsp_result_nxt = '0;
            w_rsp_zero_nxt   = 1'b0;
            w_rsp_ovf_nxt    = 1'b0;
          end
        end
      end
      ST_DRIVE: begin
        w_settle_nxt = r_settle - SET_W'(1);
        if (r_settle == SET_W'(1)) begin
          w_state_nxt      = ST_RESP;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_err_nxt    = 1'b0;
          w_rsp_result_nxt = alu_result;
          w_rsp_zero_nxt   = alu_zero;
          w_rsp_ovf_nxt    = alu_overflow & w_sel_arith;
          w_alu_a_nxt      = '0;
          w_alu_b_nxt      = '0;
          w_alu_sel_nxt    = SEL_IDLE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          if (r_done_cnt != '1) w_done_cnt_nxt = r_done_cnt + CNT_W'(1);
          if (r_rsp_err && (r_err_cnt != '1)) w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
        w_alu_a_nxt     = '0;
        w_alu_b_nxt     = '0;
        w_alu_sel_nxt   = SEL_IDLE;
      end
    endcase
  end

  assign cmd_ready  = r_cmd_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_ovf    = r_rsp_ovf;
  assign rsp_err    = r_rsp_err;
  assign rsp_tag    = r_rsp_tag;
  assign done_cnt   = r_done_cnt;
  assign err_cnt    = r_err_cnt;

endmodule
